// File: rtl/inst_rom_loader_pkg.sv
// Shared bus widths and loader FSM encodings for the boot-time
// instruction loader.
package inst_rom_loader_pkg;

  localparam int InstAddrBus    = 32;
  localparam int InstBus        = 32;
  localparam int LoaderStateBus = 3;

  typedef enum logic [LoaderStateBus-1:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } loader_state_e;

endpackage

// File: rtl/inst_rom_loader_packer.sv
// Big-endian byte-to-word packer, shared by the length header and
// the instruction words.
module inst_rom_loader_packer
  import inst_rom_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_take,
  input  logic [7:0]         i_byte,
  output logic [InstBus-1:0] o_word,
  output logic               o_word_valid
);

  logic [23:0] r_sh;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_take) begin
      r_sh  <= {r_sh[15:0], i_byte};
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // The 4th byte completes the word in the same cycle it arrives.
  assign o_word       = {r_sh, i_byte};
  assign o_word_valid = i_take && (r_cnt == 2'd3);

endmodule

// File: rtl/inst_rom_loader.sv
// Streams a length-prefixed big-endian image into instruction memory
// and holds the core in reset until the image is complete.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_data_i,
  output logic                   byte_ready_o,
  output logic                   mem_we_o,
  output logic [InstAddrBus-1:0] mem_addr_o,
  output logic [InstBus-1:0]     mem_data_o,
  output logic                   cpu_rst_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int IDX_W = $clog2(MAX_WORDS) + 1;

  loader_state_e    r_state;
  loader_state_e    w_state_nxt;
  logic             r_ready;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic             r_cpu_rst;
  logic             r_done;
  logic             r_err;
  logic [31:0]      r_len;
  logic [31:0]      w_len_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_idx_inc;
  logic             w_take;
  logic [31:0]      w_word;
  logic             w_word_valid;
  logic [31:0]      w_addr;

  assign w_take    = byte_valid_i && r_ready;
  assign w_idx_inc = r_idx + 1'b1;
  assign w_addr    = BASE_ADDR + (32'(r_idx) << 2);

  inst_rom_loader_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_take       (w_take),
    .i_byte       (byte_data_i),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      S_LEN: begin
        if (w_word_valid) begin
          w_len_nxt = w_word;
          if (w_word == 32'd0)
            w_state_nxt = S_DONE;
          else if (w_word > 32'(MAX_WORDS))
            w_state_nxt = S_ERR;
          else
            w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_word_valid)
          w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_idx_nxt = w_idx_inc;
        if (32'(w_idx_inc) == r_len)
          w_state_nxt = S_DONE;
        else
          w_state_nxt = S_DATA;
      end
      S_DONE:  w_state_nxt = S_DONE;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_LEN;
      r_len     <= '0;
      r_idx     <= '0;
      r_ready   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_idx     <= w_idx_nxt;
      r_ready   <= (w_state_nxt == S_LEN) ||
                   (w_state_nxt == S_DATA);
      r_we      <= (w_state_nxt == S_WRITE);
      r_cpu_rst <= (w_state_nxt != S_DONE);
      r_done    <= (w_state_nxt == S_DONE);
      r_err     <= (w_state_nxt == S_ERR);
      if (w_state_nxt == S_WRITE) begin
        r_addr <= w_addr;
        r_data <= w_word;
      end
    end
  end

  assign byte_ready_o = r_ready;
  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_data_o   = r_data;
  assign cpu_rst_o    = r_cpu_rst;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader (MAX_WORDS=16, BASE_ADDR=0x100).
// Writes are logged on the falling edge and checked in sequence.
module tb_inst_rom_loader;

  logic        clk;
  logic        rst;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        cpu_rst_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  int          nw = 0;
  int          rdy_bad = 0;
  logic [31:0] wa [64];
  logic [31:0] wd [64];

  inst_rom_loader #(
    .MAX_WORDS (16),
    .BASE_ADDR (32'h0000_0100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .cpu_rst_o    (cpu_rst_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we_o) begin
      if (nw < 64) begin
        wa[nw] = mem_addr_o;
        wd[nw] = mem_data_o;
      end
      if (byte_ready_o) rdy_bad++;
      nw++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input int gap);
    int n;
    byte_valid_i = 1'b0;
    repeat (gap) step();
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    n = 0;
    while (!byte_ready_o && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("put_timeout", 32'd0, 32'd1);
    step();
    byte_valid_i = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w, input int maxgap);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      put(t[31:24], $urandom_range(0, maxgap));
      t = t << 8;
    end
  endtask

  task automatic do_reset();
    byte_valid_i = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"},   32'(byte_ready_o), 32'd0);
    chk({tag, "_we"},      32'(mem_we_o),     32'd0);
    chk({tag, "_addr"},    mem_addr_o,        32'd0);
    chk({tag, "_data"},    mem_data_o,        32'd0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst_o),    32'd1);
    chk({tag, "_done"},    32'(done_o),       32'd0);
    chk({tag, "_err"},     32'(err_o),        32'd0);
  endtask

  initial begin
    int b;
    int acc;
    rst = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i = 8'h00;
    step();
    step();
    chk_reset("rst0");
    rst = 1'b1;
    step();
    chk("rst_ready_up", 32'(byte_ready_o), 32'd1);

    // single word
    b = nw;
    put_word(32'h0000_0001, 0);
    put_word(32'h3C01_1234, 0);
    chk("t1_we",      32'(mem_we_o),    32'd1);
    chk("t1_addr",    mem_addr_o,       32'h0000_0100);
    chk("t1_data",    mem_data_o,       32'h3C01_1234);
    chk("t1_ready0",  32'(byte_ready_o), 32'd0);
    chk("t1_notdone", 32'(done_o),      32'd0);
    step();
    chk("t1_done",    32'(done_o),      32'd1);
    chk("t1_cpu_rst", 32'(cpu_rst_o),   32'd0);
    chk("t1_we_off",  32'(mem_we_o),    32'd0);
    chk("t1_nw",      32'(nw - b),      32'd1);

    // bytes offered after done
    acc = 0;
    byte_valid_i = 1'b1;
    byte_data_i = 8'hAA;
    for (int i = 0; i < 6; i++) begin
      if (byte_ready_o) acc++;
      step();
    end
    byte_valid_i = 1'b0;
    chk("t6_accepts", 32'(acc),    32'd0);
    chk("t6_nw",      32'(nw - b), 32'd1);
    chk("t6_done",    32'(done_o), 32'd1);

    // three words with random gaps
    do_reset();
    b = nw;
    put_word(32'h0000_0003, 3);
    put_word(32'h1122_3344, 3);
    put_word(32'h5566_7788, 3);
    put_word(32'h99AA_BBCC, 3);
    step();
    chk("t2_done",    32'(done_o),    32'd1);
    chk("t2_cpu_rst", 32'(cpu_rst_o), 32'd0);
    chk("t2_nw",      32'(nw - b),    32'd3);
    chk("t2_a0", wa[b],   32'h0000_0100);
    chk("t2_d0", wd[b],   32'h1122_3344);
    chk("t2_a1", wa[b+1], 32'h0000_0104);
    chk("t2_d1", wd[b+1], 32'h5566_7788);
    chk("t2_a2", wa[b+2], 32'h0000_0108);
    chk("t2_d2", wd[b+2], 32'h99AA_BBCC);
    chk("t2_rdy_on_we", 32'(rdy_bad), 32'd0);

    // zero length
    do_reset();
    b = nw;
    put_word(32'h0000_0000, 0);
    chk("t3_done",    32'(done_o),    32'd1);
    chk("t3_cpu_rst", 32'(cpu_rst_o), 32'd0);
    step();
    chk("t3_nw",      32'(nw - b),    32'd0);

    // header equal to MAX_WORDS is legal
    do_reset();
    put_word(32'h0000_0010, 0);
    chk("tmax_err",   32'(err_o),        32'd0);
    chk("tmax_ready", 32'(byte_ready_o), 32'd1);

    // oversize header
    do_reset();
    b = nw;
    put_word(32'h0000_0011, 0);
    chk("t4_err",     32'(err_o),        32'd1);
    chk("t4_cpu_rst", 32'(cpu_rst_o),    32'd1);
    chk("t4_ready",   32'(byte_ready_o), 32'd0);
    acc = 0;
    byte_valid_i = 1'b1;
    byte_data_i = 8'h55;
    for (int i = 0; i < 5; i++) begin
      if (byte_ready_o) acc++;
      step();
    end
    byte_valid_i = 1'b0;
    chk("t4_accepts", 32'(acc),    32'd0);
    chk("t4_err_hold", 32'(err_o), 32'd1);
    chk("t4_nodone",  32'(done_o), 32'd0);
    chk("t4_nw",      32'(nw - b), 32'd0);

    // reset after two of three words
    do_reset();
    b = nw;
    put_word(32'h0000_0003, 1);
    put_word(32'hCAFE_0001, 1);
    put_word(32'hCAFE_0002, 1);
    step();
    chk("t5_nw_pre", 32'(nw - b), 32'd2);
    rst = 1'b0;
    step();
    chk_reset("t5rst");
    rst = 1'b1;
    step();
    b = nw;
    put_word(32'h0000_0001, 0);
    put_word(32'hDEAD_BEEF, 0);
    chk("t5_we",   32'(mem_we_o), 32'd1);
    chk("t5_addr", mem_addr_o,    32'h0000_0100);
    chk("t5_data", mem_data_o,    32'hDEAD_BEEF);
    step();
    chk("t5_done", 32'(done_o),   32'd1);
    chk("t5_nw",   32'(nw - b),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Boot-time instruction loader: upstream of the instruction memory and of the OpenMIPS core in the minimum SOPC. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them sequentially into the instruction ROM's write port. The core is held in reset until the image is complete. On completion the core is released and starts fetching from `BASE_ADDR`.

## Interface
- `MAX_WORDS`, 1024: instruction memory depth in words; upper bound on the image length.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written; must be 4-byte aligned.
- `clk`  in  1: single system clock, rising edge.
- `rst`  in  1: reset, **synchronous, active-low** (rst==0 resets on the rising edge of clk).
- `byte_valid_i`  in  1: stream byte present.
- `byte_data_i`  in  8: stream byte.
- `byte_ready_o`  out  1: loader accepts a byte this cycle.
- `mem_we_o`  out  1: one-cycle write strobe to instruction memory.
- `mem_addr_o`  out  `InstAddrBus` (32): byte address of the write.
- `mem_data_o`  out  `InstBus` (32): instruction word being written.
- `cpu_rst_o`  out  1: drives the core's reset; 1 holds the core in reset.
- `done_o`  out  1: image loaded; sticky until reset.
- `err_o`  out  1: bad length header; sticky until reset.

## Operation
- **Stream format:**
  - 4-byte big-endian word count N.
  - Then N words, 4 bytes each, big-endian (first byte is bits 31:24).
- **Byte transfer:** a byte transfers on a cycle where `byte_valid_i && byte_ready_o`. `byte_data_i` is ignored otherwise.
- **FSM states:**
  - `S_LEN`: `byte_ready_o`=1. Shifts bytes into the length register; a 2-bit byte counter tracks position.
    - 4th byte, N==0 → `S_DONE`.
    - 4th byte, N>MAX_WORDS → `S_ERR`.
    - Otherwise → `S_DATA`.
  - `S_DATA`: `byte_ready_o`=1. Shifts bytes into the word register; the 4th byte → `S_WRITE`.
  - `S_WRITE`: `byte_ready_o`=0 and `mem_we_o`=1 for exactly this cycle.
    - `mem_addr_o` = BASE_ADDR + 4·idx; `mem_data_o` = assembled word.
    - idx increments. If idx+1 == N → `S_DONE`, else → `S_DATA`.
  - `S_DONE`: `byte_ready_o`=0, `cpu_rst_o`=0, `done_o`=1. Terminal until reset.
  - `S_ERR`: `byte_ready_o`=0, `cpu_rst_o`=1, `err_o`=1. Terminal until reset.
- **Arithmetic and widths:**
  - idx has width clog2(MAX_WORDS)+1.
  - N is compared at the full 32 bits.
  - The address add is 32-bit and wraps modulo 2^32 (unreachable for legal parameters).
- **Unused bytes:** bytes offered in `S_DONE`/`S_ERR` are never accepted; the stream source stalls.

## Timing
- **Reset values** (while rst==0 on a clock edge, and the cycle after):
  - state=`S_LEN`; byte counter, idx, N and word register all 0.
  - `mem_we_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
  - `cpu_rst_o`=1, `done_o`=0, `err_o`=0.
  - `byte_ready_o`=0 during reset, 1 from the first cycle after rst rises.
- **Outputs are registered.** `mem_we_o` rises the cycle after the 4th data byte is accepted and lasts one cycle.
- **Throughput:** max one word per 5 cycles (4 accepts + 1 write).
- **Completion latency:** the `S_WRITE` cycle for the final word is followed on the next edge by `done_o`=1 and `cpu_rst_o`=0.
- **Zero length:** `done_o` and the `cpu_rst_o` release occur the cycle after the 4th length byte.
- **Reset mid-load:** rst==0 in any state aborts immediately. There is no partial-write side effect beyond words already strobed. `cpu_rst_o` returns to 1 and the header is expected again.
- **Stalls:** `byte_valid_i` gaps of any length are tolerated; the counters hold.

## Structure
- Shared defines file (`defines.v`) supplies:
  - existing `InstAddrBus` and `InstBus`;
  - new `LoaderStateBus` (2:0) and the five state encodings `S_LEN`…`S_ERR`.
- One optional sub-module: `byte_to_word_packer`. It holds the 4-byte shift register plus the 2-bit counter, with a `word_valid` pulse out. It is reused for the length header and for data words.
- SOPC integration:
  - `cpu_rst_o` drives the openmips `rst` input.
  - The loader write port muxes into `inst_rom` via a new write port. No separate boot ROM is needed.

## Test plan
1. **Single word:** reset, then stream 00 00 00 01 3C 01 12 34.
   - One `mem_we_o` pulse with addr 0x0000_0000 and data 0x3C01_1234.
   - Next cycle `done_o`=1, `cpu_rst_o`=0.
2. **Three words with BASE_ADDR=0x100 and random `byte_valid_i` gaps.**
   - Writes at 0x100, 0x104, 0x108 with matching data.
   - `byte_ready_o` is 0 exactly on each write cycle.
3. **Zero length:** stream 00 00 00 00.
   - No `mem_we_o` pulse.
   - `done_o`=1 the cycle after the 4th byte.
4. **Oversize:** MAX_WORDS=16, header 00 00 00 11.
   - `err_o`=1, `cpu_rst_o` stays 1, `byte_ready_o`=0.
   - Following bytes are not accepted.
5. **Mid-load reset:** deassert rst for one cycle after 2 of 3 words.
   - All reset values as specified.
   - A fresh header plus 1 word then writes addr BASE_ADDR.
6. **Post-done stream:** extra bytes offered after `done_o`.
   - Never accepted; no `mem_we_o`; `done_o` holds 1.
